clic_gateway: RTL and testbench

- Per-source interrupt gateway between the raw interrupt lines and the CLIC register file / arbiter.
- Synchronises each line and applies polarity and trigger mode, supporting all four modes: positive/negative level and positive/negative edge.
- Keeps edge-pending state, which is cleared by arbiter claim handshakes or by software writes.
- Drives change-only `hw2reg` updates for the IP bit, plus qualified pending vectors to the arbiter.

---
 rtl/clic_gateway.sv | 125 ++++++++++++
 tb/tb_clic_gateway.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clic_gateway.sv
// Per-source CLIC interrupt gateway: synchronises raw lines, applies trigger mode and
// polarity, tracks pending state and reports IP changes to the register file.
module clic_gateway #(
   parameter int N_SOURCE    = 32,
   parameter int SYNC_STAGES = 2,
   parameter int IdWidth     = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [N_SOURCE-1:0]   irq_i,
   input  logic [2*N_SOURCE-1:0] trig_i,
   input  logic [N_SOURCE-1:0]   ie_i,
   input  logic [N_SOURCE-1:0]   sw_ip_we_i,
   input  logic [N_SOURCE-1:0]   sw_ip_wd_i,
   input  logic                  claim_valid_i,
   input  logic [IdWidth-1:0]    claim_id_i,
   output logic                  claim_ready_o,
   output logic                  claim_ack_o,
   output logic                  claim_err_o,
   output logic                  claim_was_pend_o,
   output logic [N_SOURCE-1:0]   ip_o,
   output logic [N_SOURCE-1:0]   pend_o,
   output logic [N_SOURCE-1:0]   le_o,
   output logic [N_SOURCE-1:0]   ip_de_o,
   output logic [N_SOURCE-1:0]   ip_d_o
);

   logic [N_SOURCE-1:0]   s;
   logic [2*N_SOURCE-1:0] trig_q, trig_prev_q;
   logic [N_SOURCE-1:0]   prev_q, ip_q, ip_d, ip_dly_q, ip_de_q, ip_dq;
   logic [N_SOURCE-1:0]   lvl, edg, edge_mode, mode_chg, claim_hit;
   logic                  ack_q, err_q, was_pend_q;
   logic                  accept, id_ok, was_pend_d;
   logic [31:0]           id_ext;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = irq_i;
      end else begin : g_sync
         logic [N_SOURCE-1:0] sync_q [SYNC_STAGES];
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            end else begin
               sync_q[0] <= irq_i;
               for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            end
         end
         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // Claim handshake: a claim is accepted when claim_valid_i && claim_ready_o;
   // ready drops for the ack cycle so acks are single-cycle and never back-to-back.
   assign claim_ready_o = ~ack_q;
   assign accept        = claim_valid_i & claim_ready_o;
   assign id_ext        = 32'(claim_id_i);
   assign id_ok         = id_ext < 32'(N_SOURCE);

   always_comb begin
      lvl        = '0;
      edg        = '0;
      edge_mode  = '0;
      mode_chg   = '0;
      claim_hit  = '0;
      ip_d       = ip_q;
      for (int i = 0; i < N_SOURCE; i++) begin
         lvl[i]       = s[i] ^ trig_q[2*i+1];
         edg[i]       = lvl[i] & ~prev_q[i];
         edge_mode[i] = trig_q[2*i];
         // trig_q is compared with its previous value so the clear lands in the
         // first cycle the new mode is in effect.
         mode_chg[i]  = (trig_q[2*i] != trig_prev_q[2*i]) |
                        (trig_q[2*i+1] != trig_prev_q[2*i+1]);
         claim_hit[i] = accept & id_ok & (id_ext == i);
         if (!edge_mode[i])       ip_d[i] = lvl[i];
         else if (mode_chg[i])    ip_d[i] = 1'b0;
         else if (edg[i])         ip_d[i] = 1'b1;
         else if (claim_hit[i])   ip_d[i] = 1'b0;
         else if (sw_ip_we_i[i])  ip_d[i] = sw_ip_wd_i[i];
         else                     ip_d[i] = ip_q[i];
      end
      was_pend_d = |(ip_q & claim_hit);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         trig_q      <= '0;
         trig_prev_q <= '0;
         prev_q      <= '1;
         ip_q        <= '0;
         ip_dly_q    <= '0;
         ip_de_q     <= '0;
         ip_dq       <= '0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         was_pend_q  <= 1'b0;
      end else begin
         trig_q      <= trig_i;
         trig_prev_q <= trig_q;
         prev_q      <= lvl;
         ip_q        <= ip_d;
         ip_dly_q    <= ip_q;
         ip_de_q     <= ip_q ^ ip_dly_q;
         ip_dq       <= ip_q;
         ack_q       <= accept;
         err_q       <= accept & ~id_ok;
         was_pend_q  <= was_pend_d;
      end
   end

   always_comb begin
      le_o = '0;
      for (int i = 0; i < N_SOURCE; i++) le_o[i] = trig_q[2*i];
   end

   assign claim_ack_o      = ack_q;
   assign claim_err_o      = err_q;
   assign claim_was_pend_o = was_pend_q;
   assign ip_o             = ip_q;
   assign pend_o           = ip_q & ie_i;
   assign ip_de_o          = ip_de_q;
   assign ip_d_o           = ip_dq;

endmodule

// File: tb/tb_clic_gateway.sv
// Directed bench for clic_gateway with 5 sources and a 2-stage synchroniser.
module tb_clic_gateway;

   localparam int N  = 5;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  irq, ie, sw_we, sw_wd;
   logic [2*N-1:0] trig;
   logic          claim_valid;
   logic [IW-1:0] claim_id;
   logic          claim_ready, claim_ack, claim_err, claim_was_pend;
   logic [N-1:0]  ip, pend, le, ip_de, ip_dd;

   int tests = 0;
   int fails = 0;
   int acks  = 0;

   clic_gateway #(.N_SOURCE(N), .SYNC_STAGES(2)) dut (
      .clk_i(clk), .rst_i(rst), .irq_i(irq), .trig_i(trig), .ie_i(ie),
      .sw_ip_we_i(sw_we), .sw_ip_wd_i(sw_wd),
      .claim_valid_i(claim_valid), .claim_id_i(claim_id),
      .claim_ready_o(claim_ready), .claim_ack_o(claim_ack), .claim_err_o(claim_err),
      .claim_was_pend_o(claim_was_pend), .ip_o(ip), .pend_o(pend), .le_o(le),
      .ip_de_o(ip_de), .ip_d_o(ip_dd)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // src0 pos-edge, src1 neg-edge, src2 neg-level, src3 pos-edge, src4 pos-edge
   localparam logic [2*N-1:0] TRIG_CFG = 10'b01_01_10_11_01;
   localparam logic [2*N-1:0] TRIG_S4L = 10'b00_01_10_11_01;

   initial begin
      rst = 1'b1; irq = '0; ie = '1; sw_we = '0; sw_wd = '0;
      trig = TRIG_CFG; claim_valid = 1'b0; claim_id = '0;
      tick(3);
      check("rst_ip", 32'(ip), 32'h0);
      check("rst_ack", 32'(claim_ack), 32'h0);
      check("rst_de", 32'(ip_de), 32'h0);
      check("rst_le", 32'(le), 32'h0);
      check("rst_ready", 32'(claim_ready), 32'h1);
      rst = 1'b0;
      tick(5);
      check("post_rst_ip_no_glitch", 32'(ip), 32'h04);
      check("le_cfg", 32'(le), 32'h1b);
      check("post_rst_de_idle", 32'(ip_de), 32'h0);

      // positive edge on src3: ip after 3 cycles, de one later
      irq = 5'b01000;
      tick(2);
      check("s3_ip_early", 32'(ip), 32'h04);
      tick();
      check("s3_ip_set", 32'(ip), 32'h0c);
      check("s3_de_early", 32'(ip_de), 32'h0);
      tick();
      check("s3_de", 32'(ip_de), 32'h08);
      check("s3_d", 32'(ip_dd), 32'h0c);
      tick();
      check("s3_de_end", 32'(ip_de), 32'h0);

      claim_valid = 1'b1; claim_id = 3'd3;
      check("s3_ready", 32'(claim_ready), 32'h1);
      tick();
      claim_valid = 1'b0;
      check("s3_ack", 32'(claim_ack), 32'h1);
      check("s3_was_pend", 32'(claim_was_pend), 32'h1);
      check("s3_err", 32'(claim_err), 32'h0);
      check("s3_cleared", 32'(ip), 32'h04);
      check("s3_ready_low", 32'(claim_ready), 32'h0);
      tick();
      check("s3_ack_end", 32'(claim_ack), 32'h0);

      // edge on src0 coincident with its claim
      irq = 5'b01001;
      tick(3);
      check("s0_pend", 32'(ip), 32'h05);
      irq = 5'b01000;
      tick(3);
      check("s0_fall_hold", 32'(ip), 32'h05);
      irq = 5'b01001;
      tick(2);
      claim_valid = 1'b1; claim_id = 3'd0;
      tick();
      claim_valid = 1'b0;
      check("coll_ack", 32'(claim_ack), 32'h1);
      check("coll_was_pend", 32'(claim_was_pend), 32'h1);
      check("coll_ip_kept", 32'(ip), 32'h05);
      tick();

      // software clear of src0 plus a no-op write to src1
      sw_we = 5'b00011; sw_wd = 5'b00000;
      tick();
      sw_we = '0;
      check("sw_clr_ip", 32'(ip), 32'h04);
      tick();
      check("sw_clr_de", 32'(ip_de), 32'h01);

      // level-mode source ignores claims and software writes
      claim_valid = 1'b1; claim_id = 3'd2;
      tick();
      claim_valid = 1'b0;
      check("lvl_ack", 32'(claim_ack), 32'h1);
      check("lvl_was_pend", 32'(claim_was_pend), 32'h1);
      check("lvl_claim_keep", 32'(ip), 32'h04);
      sw_we = 5'b00100; sw_wd = 5'b00000;
      tick();
      sw_we = '0;
      check("lvl_sw_keep", 32'(ip), 32'h04);
      irq = 5'b01100;
      tick(2);
      check("lvl_hold", 32'(ip), 32'h04);
      tick();
      check("lvl_drop", 32'(ip), 32'h00);

      // disabled source still latches pending
      sw_we = 5'b00001; sw_wd = 5'b00001;
      tick();
      sw_we = '0; sw_wd = '0;
      check("sw_set_ip", 32'(ip), 32'h01);
      ie = 5'b11110;
      #1;
      check("pend_masked", 32'(pend), 32'h00);
      ie = 5'b11111;
      #1;
      check("pend_enabled", 32'(pend), 32'h01);

      // mode switches on src4
      irq = 5'b11100;
      tick(3);
      check("s4_pend", 32'(ip), 32'h11);
      trig = TRIG_S4L;
      tick(3);
      check("s4_level_hi", 32'(ip), 32'h11);
      check("s4_le", 32'(le), 32'h0b);
      irq = 5'b01100;
      tick(2);
      check("s4_level_lag", 32'(ip), 32'h11);
      tick();
      check("s4_level_lo", 32'(ip), 32'h01);
      irq = 5'b11100;
      tick(3);
      check("s4_level_hi2", 32'(ip), 32'h11);
      trig = TRIG_CFG;
      tick();
      check("s4_switch_pre", 32'(ip), 32'h11);
      tick();
      check("s4_switch_clr", 32'(ip), 32'h01);
      tick(3);
      check("s4_edge_idle", 32'(ip), 32'h01);
      check("s4_le_back", 32'(le), 32'h1b);

      // out-of-range claim
      claim_valid = 1'b1; claim_id = 3'd7;
      tick();
      claim_valid = 1'b0;
      check("bad_ack", 32'(claim_ack), 32'h1);
      check("bad_err", 32'(claim_err), 32'h1);
      check("bad_was_pend", 32'(claim_was_pend), 32'h0);
      check("bad_ip", 32'(ip), 32'h01);
      tick();
      check("bad_err_end", 32'(claim_err), 32'h0);

      // back-to-back claims of src0
      claim_valid = 1'b1; claim_id = 3'd0;
      check("bb_ready0", 32'(claim_ready), 32'h1);
      for (int k = 0; k < 4; k++) begin
         tick();
         if (claim_ack) acks++;
         if (k == 0) begin
            check("bb_ready1", 32'(claim_ready), 32'h0);
            check("bb_was_pend1", 32'(claim_was_pend), 32'h1);
         end
         if (k == 1) check("bb_ready2", 32'(claim_ready), 32'h1);
         if (k == 2) check("bb_was_pend2", 32'(claim_was_pend), 32'h0);
      end
      claim_valid = 1'b0;
      check("bb_acks", 32'(acks), 32'h2);
      check("bb_ip", 32'(ip), 32'h00);

      // reset in the middle of an ack with a de pulse queued
      sw_we = 5'b01000; sw_wd = 5'b01000;
      tick();
      sw_we = '0; sw_wd = '0;
      check("mid_pend", 32'(ip), 32'h08);
      claim_valid = 1'b1; claim_id = 3'd3;
      tick();
      claim_valid = 1'b0;
      check("mid_ack", 32'(claim_ack), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ack", 32'(claim_ack), 32'h0);
      check("mid_rst_was_pend", 32'(claim_was_pend), 32'h0);
      check("mid_rst_de", 32'(ip_de), 32'h0);
      check("mid_rst_ip", 32'(ip), 32'h0);
      tick(2);
      rst = 1'b0;
      tick(2);
      check("post_mid_ack", 32'(claim_ack), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
